coef_sequencer: RTL and testbench
=================================

Name: coef_sequencer

Overview:
- Sequences the VLI amplitude decoder for one 8x8 block of entropy-decoded symbols.
- Accepts (run, size, amplitude-bits) symbols from the Huffman stage and applies per-component DC prediction.
- Expands zero runs, ZRL and EOB, and streams 64 coefficients in zigzag order (index 0..63) to the dequantiser/zigzag buffer.
- Instantiates one vli_decoder internally.

Parameters:
- NUM_COMP, 3, number of colour components with independent DC predictors (max 4).
- COEF_W, 12, coefficient and predictor width (signed).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- comp_sel  in  2  component of the current block; sampled on DC symbol accept
- pred_clr  in  1  one-cycle pulse that zeroes all DC predictors (restart marker)
- sym_valid  in  1  symbol valid
- sym_ready  out  1  symbol accepted when sym_valid && sym_ready
- sym_run  in  4  zero run (ignored for DC)
- sym_size  in  4  amplitude bit count
- sym_bits  in  11  amplitude bits, right-aligned
- coef_valid  out  1  coefficient valid
- coef_ready  in  1  downstream ready
- coef_idx  out  6  zigzag index
- coef_value  out  COEF_W  signed coefficient
- blk_done  out  1  one-cycle pulse, the cycle after the idx-63 handshake
- err  out  1  sticky protocol error, cleared only by reset

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=S_DC; next-index k=0; zero count=0; all predictors=0; coef_valid=0; coef_idx=0; coef_value=0; blk_done=0; err=0. Reset mid-block abandons the block with no further output.
- States: S_DC (await DC), S_AC (await AC), S_ZERO (emit zeros), S_VAL (emit nonzero), S_FILL (EOB fill).
- sym_ready = (state==S_DC || state==S_AC), combinational from state only. No symbol is accepted while emitting.
- Output handshake: coef_* is registered and held stable while coef_valid && !coef_ready. Exactly one index per handshake; indices strictly increase 0..63, with none skipped or repeated.
- Latency: first coefficient for an accepted symbol is valid the cycle after acceptance.
- DC accept:
  - diff = vli(sym_size, sym_bits); value = pred[comp_sel] + diff, modulo 2^COEF_W (two's-complement wrap); pred[comp_sel] updated to value.
  - k=0, go S_VAL.
  - sym_size 12..15: err=1, diff=0.
- pred_clr: coincident with a DC accept, the clear applies first, so the prediction uses 0. Otherwise predictors clear the next cycle.
- AC accept with size 1..10: zcnt=run.
  - If k+run>63: err=1, value dropped, zeros emitted k..63.
  - Otherwise zeros k..k+run-1 (S_ZERO), then value at k+run (S_VAL).
- ZRL (run=15, size=0): 16 zeros via S_ZERO, then S_AC. If the run reaches idx 63, the block ends. Overflow past 63 sets err=1 and truncates at 63.
- EOB (run=0, size=0): S_FILL emits zeros k..63.
- Illegal AC (size=0 with run 1..14, or size 11..15): err=1, treated as EOB.
- Block end: the handshake at idx 63 from any emitting state gives blk_done=1 the next cycle, return to S_DC, k=0. A symbol after a block naturally reaching idx 63 is decoded as DC (no EOB needed).
- After a non-final S_VAL handshake: k++, go S_AC.

Test Plan:
- DC prediction: comp0 DC size3 bits 010 -> idx0=-5, then EOB -> idx1..63=0 and blk_done. Next block comp0 DC size2 bits 11 -> idx0=-2 (pred -5+3).
- AC runs: after DC, AC run2 size1 bits1 -> idx1=0, idx2=0, idx3=+1. Then run0 size1 bits0 -> idx4=-1. Then EOB -> idx5..63=0. err stays 0.
- ZRL to full block: ZRL x3 -> idx1..48=0; run14 size1 bits1 -> idx49..62=0, idx63=+1, blk_done. Next symbol (size0) yields a DC idx0 equal to the prior prediction.
- Overflow: at k=60, AC run5 size2 -> idx60..63=0, err=1, nonzero dropped, blk_done. An illegal run3 size0 in a later block -> EOB fill.
- Backpressure: hold coef_ready low 3 cycles mid zero-run -> coef_idx/value stable, sym_ready=0 throughout, no duplicated or missing index.
- Clears: comp1 pred=100, pred_clr coincident with DC size0 -> idx0=0. Reset asserted at idx 20 -> outputs zero immediately, sym_ready=1 after release, next symbol treated as DC.

Source files
------------

// File: rtl/coef_sequencer.sv
// Coefficient sequencer for one 8x8 block. Turns Huffman (run, size, bits)
// symbols into 64 zigzag-ordered coefficients. It also applies per-component
// DC prediction and expands zero runs, ZRL and EOB.

// Sign-magnitude VLI amplitude decode. size 0 gives 0, and sizes above 11 also give 0.
module vli_decoder #(
    parameter int unsigned OUT_W = 12
) (
    input  logic [3:0]              size,
    input  logic [10:0]             bits,
    output logic signed [OUT_W-1:0] value
);
    logic [11:0]        mask;
    logic [11:0]        top;
    logic [11:0]        mag;
    logic signed [12:0] ext;

    // A clear top bit marks a negative amplitude: value = bits - (2^size - 1)
    always_comb begin
        mask = (12'd1 << size) - 12'd1;
        top  = mask ^ (mask >> 1);
        mag  = {1'b0, bits} & mask;
        ext  = '0;
        if (size != 4'd0 && size <= 4'd11) begin
            if ((mag & top) != 12'd0) begin
                ext = signed'({1'b0, mag});
            end else begin
                ext = signed'({1'b0, mag}) - signed'({1'b0, mask});
            end
        end
    end

    assign value = OUT_W'(ext);
endmodule

module coef_sequencer #(
    parameter int unsigned NUM_COMP = 3,
    parameter int unsigned COEF_W   = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        comp_sel,
    input  logic              pred_clr,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [3:0]        sym_run,
    input  logic [3:0]        sym_size,
    input  logic [10:0]       sym_bits,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [5:0]        coef_idx,
    output logic [COEF_W-1:0] coef_value,
    output logic              blk_done,
    output logic              err
);
    typedef enum logic [2:0] {S_DC, S_AC, S_ZERO, S_VAL, S_FILL} state_t;

    state_t             state;
    logic [5:0]         k;          // next index to be produced by an AC symbol
    logic [3:0]         zcnt;       // zeros still to emit after the one presented
    logic               val_pend;   // a nonzero value follows the zero run
    logic [COEF_W-1:0]  val_hold;
    logic [COEF_W-1:0]  pred [NUM_COMP];

    logic signed [COEF_W-1:0] diff;
    logic [COEF_W-1:0]        pred_cur;
    logic [COEF_W-1:0]        dc_value;
    logic                     handshake;
    logic [6:0]               k_plus_run;
    logic                     is_eob;
    logic                     is_zrl;
    logic                     ac_legal;
    logic                     at_end;

    vli_decoder #(
        .OUT_W (COEF_W)
    ) u_vli (
        .size  (sym_size),
        .bits  (sym_bits),
        .value (diff)
    );

    assign sym_ready  = (state == S_DC) || (state == S_AC);
    assign handshake  = coef_valid && coef_ready;
    assign at_end     = (coef_idx == 6'd63);
    assign k_plus_run = {1'b0, k} + {3'b000, sym_run};
    assign is_eob     = (sym_run == 4'd0) && (sym_size == 4'd0);
    assign is_zrl     = (sym_run == 4'd15) && (sym_size == 4'd0);
    assign ac_legal   = (sym_size >= 4'd1) && (sym_size <= 4'd10);
    assign dc_value   = pred_cur + diff;

    // Predictor of the selected component; a coincident clear wins
    always_comb begin
        pred_cur = '0;
        for (int i = 0; i < int'(NUM_COMP); i++) begin
            if (comp_sel == 2'(i)) pred_cur = pred[i];
        end
        if (pred_clr) pred_cur = '0;
    end

    // Symbol accept, coefficient emission and predictor state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_DC;
            k          <= '0;
            zcnt       <= '0;
            val_pend   <= 1'b0;
            val_hold   <= '0;
            coef_valid <= 1'b0;
            coef_idx   <= '0;
            coef_value <= '0;
            blk_done   <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < int'(NUM_COMP); i++) pred[i] <= '0;
        end else begin
            blk_done <= 1'b0;
            if (pred_clr) begin
                for (int i = 0; i < int'(NUM_COMP); i++) pred[i] <= '0;
            end
            unique case (state)
                S_DC: begin
                    if (sym_valid) begin
                        if (sym_size >= 4'd12) err <= 1'b1;
                        for (int i = 0; i < int'(NUM_COMP); i++) begin
                            if (comp_sel == 2'(i)) pred[i] <= dc_value;
                        end
                        coef_valid <= 1'b1;
                        coef_idx   <= 6'd0;
                        coef_value <= dc_value;
                        k          <= 6'd0;
                        state      <= S_VAL;
                    end
                end
                S_AC: begin
                    if (sym_valid) begin
                        coef_valid <= 1'b1;
                        coef_idx   <= k;
                        coef_value <= '0;
                        if (ac_legal) begin
                            if (k_plus_run > 7'd63) begin
                                // Value would land past 63: drop it, zero-fill the rest
                                err   <= 1'b1;
                                state <= S_FILL;
                            end else if (sym_run == 4'd0) begin
                                coef_value <= diff;
                                state      <= S_VAL;
                            end else begin
                                zcnt     <= sym_run - 4'd1;
                                val_pend <= 1'b1;
                                val_hold <= diff;
                                state    <= S_ZERO;
                            end
                        end else if (is_zrl) begin
                            if (k_plus_run > 7'd63) err <= 1'b1;
                            zcnt     <= 4'd15;
                            val_pend <= 1'b0;
                            state    <= S_ZERO;
                        end else begin
                            if (!is_eob) err <= 1'b1;
                            state <= S_FILL;
                        end
                    end
                end
                S_ZERO: begin
                    if (handshake) begin
                        if (at_end) begin
                            blk_done   <= 1'b1;
                            coef_valid <= 1'b0;
                            val_pend   <= 1'b0;
                            k          <= 6'd0;
                            state      <= S_DC;
                        end else if (zcnt != 4'd0) begin
                            coef_idx <= coef_idx + 6'd1;
                            zcnt     <= zcnt - 4'd1;
                        end else if (val_pend) begin
                            coef_idx   <= coef_idx + 6'd1;
                            coef_value <= val_hold;
                            val_pend   <= 1'b0;
                            state      <= S_VAL;
                        end else begin
                            coef_valid <= 1'b0;
                            k          <= coef_idx + 6'd1;
                            state      <= S_AC;
                        end
                    end
                end
                S_VAL: begin
                    if (handshake) begin
                        coef_valid <= 1'b0;
                        if (at_end) begin
                            blk_done <= 1'b1;
                            k        <= 6'd0;
                            state    <= S_DC;
                        end else begin
                            k     <= coef_idx + 6'd1;
                            state <= S_AC;
                        end
                    end
                end
                S_FILL: begin
                    if (handshake) begin
                        if (at_end) begin
                            blk_done   <= 1'b1;
                            coef_valid <= 1'b0;
                            k          <= 6'd0;
                            state      <= S_DC;
                        end else begin
                            coef_idx <= coef_idx + 6'd1;
                        end
                    end
                end
                default: state <= S_DC;
            endcase
        end
    end
endmodule

// File: tb/tb_coef_sequencer.sv
// Bench for coef_sequencer: directed table, backpressure/reset sequences and
// randomized blocks checked against a symbol-level reference model.
module tb_coef_sequencer;
    localparam int COEF_W = 12;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        comp_sel;
    logic              pred_clr;
    logic              sym_valid;
    logic              sym_ready;
    logic [3:0]        sym_run;
    logic [3:0]        sym_size;
    logic [10:0]       sym_bits;
    logic              coef_valid;
    logic              coef_ready;
    logic [5:0]        coef_idx;
    logic [COEF_W-1:0] coef_value;
    logic              blk_done;
    logic              err;

    coef_sequencer #(
        .NUM_COMP (3),
        .COEF_W   (COEF_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .comp_sel   (comp_sel),
        .pred_clr   (pred_clr),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_run    (sym_run),
        .sym_size   (sym_size),
        .sym_bits   (sym_bits),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_idx   (coef_idx),
        .coef_value (coef_value),
        .blk_done   (blk_done),
        .err        (err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {int idx; int val;} coef_t;
    coef_t exp_q[$];

    // Reference model: block position, predictors and sticky error
    int m_pred[3];
    int m_k;
    bit m_in_block;
    bit m_err;

    function automatic int vli(int size, int bits);
        int v;
        if (size == 0 || size > 11) return 0;
        v = bits % (1 << size);
        if (v >= (1 << (size - 1))) return v;
        return v - ((1 << size) - 1);
    endfunction

    function automatic int wrap12(int x);
        int y;
        y = x & 4095;
        return (y >= 2048) ? y - 4096 : y;
    endfunction

    function automatic void m_push(int val, bit en);
        coef_t c;
        c.idx = m_k;
        c.val = val;
        if (en) exp_q.push_back(c);
        if (m_k == 63) begin
            m_in_block = 1'b0;
            m_k = 0;
        end else begin
            m_k++;
        end
    endfunction

    function automatic void model_sym(int run, int size, int bits, int comp, bit clr, bit en);
        int d;
        if (clr) foreach (m_pred[i]) m_pred[i] = 0;
        if (!m_in_block) begin
            d = 0;
            if (size >= 12) m_err = 1'b1;
            else d = vli(size, bits);
            m_pred[comp] = wrap12(m_pred[comp] + d);
            m_in_block = 1'b1;
            m_k = 0;
            m_push(m_pred[comp], en);
        end else if (size >= 1 && size <= 10) begin
            if (m_k + run > 63) begin
                m_err = 1'b1;
                while (m_in_block) m_push(0, en);
            end else begin
                repeat (run) m_push(0, en);
                m_push(vli(size, bits), en);
            end
        end else if (run == 15 && size == 0) begin
            if (m_k + 16 > 64) m_err = 1'b1;
            for (int i = 0; i < 16 && m_in_block; i++) m_push(0, en);
        end else begin
            if (!(run == 0 && size == 0)) m_err = 1'b1;
            while (m_in_block) m_push(0, en);
        end
    endfunction

    function automatic void model_reset();
        foreach (m_pred[i]) m_pred[i] = 0;
        m_k = 0;
        m_in_block = 1'b0;
        m_err = 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Present one symbol. With use_model the model supplies the expected stream,
    // otherwise the zeros first..last-1 followed by val at last are expected.
    task automatic send(input int run, input int size, input int bits, input int comp,
                        input bit clr, input bit use_model,
                        input int first, input int last, input int val);
        int t;
        coef_t c;
        t = 0;
        @(negedge clock);
        while (!sym_ready && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (!sym_ready) begin
            chk("send_timeout", 0, 1);
            return;
        end
        sym_valid = 1'b1;
        sym_run   = 4'(run);
        sym_size  = 4'(size);
        sym_bits  = 11'(bits);
        comp_sel  = 2'(comp);
        pred_clr  = clr;
        model_sym(run, size, bits, comp, clr, use_model);
        if (!use_model) begin
            for (int j = first; j <= last; j++) begin
                c.idx = j;
                c.val = (j == last) ? val : 0;
                exp_q.push_back(c);
            end
        end
        @(negedge clock);
        sym_valid = 1'b0;
        pred_clr  = 1'b0;
    endtask

    task automatic send_m(input int run, input int size, input int bits, input int comp,
                          input bit clr);
        send(run, size, bits, comp, clr, 1'b1, 0, 0, 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || coef_valid) && t < 5000) begin
            @(negedge clock);
            t++;
        end
        chk("idle_timeout", int'(exp_q.size() != 0 || coef_valid), 0);
    endtask

    // Output monitor: random ready, stream/hold/blk_done/sym_ready checks
    bit                hold_ready = 1'b0;
    bit                blk_exp    = 1'b0;
    bit                stalled    = 1'b0;
    logic [5:0]        st_idx;
    logic [COEF_W-1:0] st_val;

    always @(negedge clock) begin
        coef_t c;
        if (reset) begin
            stalled    = 1'b0;
            blk_exp    = 1'b0;
            coef_ready = 1'b0;
        end else begin
            chk("blk_done", int'(blk_done), int'(blk_exp));
            blk_exp = 1'b0;
            if (stalled) begin
                chk("hold_valid", int'(coef_valid), 1);
                chk("hold_idx", int'(coef_idx), int'(st_idx));
                chk("hold_value", int'(coef_value), int'(st_val));
            end
            if (coef_valid) chk("sym_ready_emit", int'(sym_ready), 0);
            coef_ready = hold_ready ? 1'b0 : ($urandom_range(0, 9) < 7);
            stalled = coef_valid && !coef_ready;
            st_idx  = coef_idx;
            st_val  = coef_value;
            if (coef_valid && coef_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_coef_idx", int'(coef_idx), -1);
                end else begin
                    c = exp_q.pop_front();
                    chk("coef_idx", int'(coef_idx), c.idx);
                    chk("coef_value", int'($signed(coef_value)), c.val);
                    if (c.idx == 63) blk_exp = 1'b1;
                end
            end
        end
    end

    typedef struct {
        int comp; bit clr; int run; int size; int bits;
        int first; int last; int val; bit err;
    } vec_t;
    vec_t tbl[21];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int r;
        int run;
        int size;
        int nsym;
        logic [5:0]        rec_idx;
        logic [COEF_W-1:0] rec_val;

        // comp, clr, run, size, bits, first, last, val, err
        tbl[0]  = '{0, 1'b0, 0, 3, 'b010,     0,  0, -5, 1'b0};
        tbl[1]  = '{0, 1'b0, 0, 0, 0,         1, 63,  0, 1'b0};
        tbl[2]  = '{0, 1'b0, 0, 2, 'b11,      0,  0, -2, 1'b0};
        tbl[3]  = '{0, 1'b0, 2, 1, 1,         1,  3,  1, 1'b0};
        tbl[4]  = '{0, 1'b0, 0, 1, 0,         4,  4, -1, 1'b0};
        tbl[5]  = '{0, 1'b0, 0, 0, 0,         5, 63,  0, 1'b0};
        tbl[6]  = '{0, 1'b0, 0, 0, 0,         0,  0, -2, 1'b0};
        tbl[7]  = '{0, 1'b0, 15, 0, 0,        1, 16,  0, 1'b0};
        tbl[8]  = '{0, 1'b0, 15, 0, 0,       17, 32,  0, 1'b0};
        tbl[9]  = '{0, 1'b0, 15, 0, 0,       33, 48,  0, 1'b0};
        tbl[10] = '{0, 1'b0, 14, 1, 1,       49, 63,  1, 1'b0};
        tbl[11] = '{0, 1'b0, 0, 0, 0,         0,  0, -2, 1'b0};
        tbl[12] = '{0, 1'b0, 15, 0, 0,        1, 16,  0, 1'b0};
        tbl[13] = '{0, 1'b0, 15, 0, 0,       17, 32,  0, 1'b0};
        tbl[14] = '{0, 1'b0, 15, 0, 0,       33, 48,  0, 1'b0};
        tbl[15] = '{0, 1'b0, 10, 1, 1,       49, 59,  1, 1'b0};
        tbl[16] = '{0, 1'b0, 5, 2, 'b01,     60, 63,  0, 1'b1};
        tbl[17] = '{1, 1'b0, 0, 7, 'b1100100, 0,  0, 100, 1'b1};
        tbl[18] = '{1, 1'b0, 3, 0, 0,         1, 63,  0, 1'b1};
        tbl[19] = '{1, 1'b1, 0, 0, 0,         0,  0,  0, 1'b1};
        tbl[20] = '{1, 1'b0, 0, 0, 0,         1, 63,  0, 1'b1};

        reset = 1'b1; comp_sel = '0; pred_clr = 1'b0; sym_valid = 1'b0;
        sym_run = '0; sym_size = '0; sym_bits = '0; coef_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_coef_valid", int'(coef_valid), 0);
        chk("rst_coef_idx", int'(coef_idx), 0);
        chk("rst_coef_value", int'(coef_value), 0);
        chk("rst_blk_done", int'(blk_done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sym_ready", int'(sym_ready), 1);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 21; i++) begin
            send(tbl[i].run, tbl[i].size, tbl[i].bits, tbl[i].comp, tbl[i].clr, 1'b0,
                 tbl[i].first, tbl[i].last, tbl[i].val);
            wait_idle();
            chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].err));
        end

        // Backpressure mid zero-run
        send_m(0, 0, 0, 2, 1'b0);
        send_m(12, 1, 1, 2, 1'b0);
        t = 0;
        while (!(coef_valid && coef_idx >= 6'd3 && coef_idx <= 6'd8) && t < 500) begin
            @(posedge clock);
            #2;
            t++;
        end
        chk("bp_reach_zero_run", int'(coef_valid && coef_idx >= 6'd3 && coef_idx <= 6'd8), 1);
        hold_ready = 1'b1;
        @(negedge clock);
        #1;
        rec_idx = coef_idx;
        rec_val = coef_value;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            chk("bp_idx", int'(coef_idx), int'(rec_idx));
            chk("bp_value", int'(coef_value), int'(rec_val));
            chk("bp_sym_ready", int'(sym_ready), 0);
        end
        hold_ready = 1'b0;
        send_m(0, 0, 0, 2, 1'b0);
        wait_idle();

        // Reset in the middle of a block at idx 20
        send_m(0, 4, 9, 0, 1'b0);
        send_m(0, 0, 0, 0, 1'b0);
        t = 0;
        while (!(coef_valid && coef_idx == 6'd20) && t < 500) begin
            @(negedge clock);
            t++;
        end
        chk("rst_reach_idx20", int'(coef_valid && coef_idx == 6'd20), 1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        chk("midrst_coef_valid", int'(coef_valid), 0);
        chk("midrst_coef_idx", int'(coef_idx), 0);
        chk("midrst_coef_value", int'(coef_value), 0);
        chk("midrst_err", int'(err), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_sym_ready", int'(sym_ready), 1);
        send(0, 2, 'b11, 0, 1'b0, 1'b0, 0, 0, 3);
        send_m(0, 0, 0, 0, 1'b0);
        wait_idle();
        chk("midrst_err_after", int'(err), 0);

        // Randomized blocks against the model
        for (int b = 0; b < 40; b++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clock);
                pred_clr = 1'b1;
                foreach (m_pred[i]) m_pred[i] = 0;
                @(negedge clock);
                pred_clr = 1'b0;
            end
            size = ($urandom_range(0, 19) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
            send_m(0, size, int'($urandom & 2047), $urandom_range(0, 2),
                   $urandom_range(0, 9) == 0);
            nsym = 0;
            while (m_in_block) begin
                r = $urandom_range(0, 99);
                if (nsym > 20) begin
                    send_m(0, 0, 0, 0, 1'b0);
                end else if (r < 65) begin
                    run = (r < 40) ? $urandom_range(0, 3) : $urandom_range(0, 15);
                    send_m(run, $urandom_range(1, 10), int'($urandom & 2047), 0, 1'b0);
                end else if (r < 80) begin
                    send_m(15, 0, 0, 0, 1'b0);
                end else if (r < 92) begin
                    send_m(0, 0, 0, 0, 1'b0);
                end else if (r < 96) begin
                    send_m($urandom_range(1, 14), 0, 0, 0, 1'b0);
                end else begin
                    send_m($urandom_range(0, 15), $urandom_range(11, 15), int'($urandom & 2047),
                           0, 1'b0);
                end
                nsym++;
            end
            if (b % 8 == 7) begin
                wait_idle();
                chk("rand_err", int'(err), int'(m_err));
            end
        end
        wait_idle();
        chk("final_err", int'(err), int'(m_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
